// File: rtl/frame_pkg.sv
// Frame buffer constants and reader state encoding shared by the
// canny pixel packer (writer) and pixel_frame_reader.
package frame_pkg;

  localparam int         FRAME_BYTES = 5100;
  localparam logic [7:0] FRAME_HDR0  = 8'hAA;
  localparam logic [7:0] FRAME_HDR1  = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } reader_state_t;

  // A 1-entry buffer still needs a 1-bit address.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_reader_if.sv
// Frame buffer read port plus the byte stream towards the UART transmitter.
// tx stream: a byte moves on a clk edge where tx_valid & tx_ready; once raised,
// tx_valid stays high and tx_data stays stable until that transfer happens.
interface pixel_frame_reader_if #(
  parameter int ADDR_W = 13
);
  logic              rEn;
  logic [ADDR_W-1:0] rAddr;
  logic [7:0]        rData;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rEn, rAddr, tx_data, tx_valid,
    input  rData, tx_ready
  );

  modport slave (
    input  rEn, rAddr, tx_data, tx_valid,
    output rData, tx_ready
  );
endinterface

// File: rtl/pixel_frame_reader.sv
// Streams the packed edge frame buffer to the UART as one packet:
// HDR0, HDR1, DEPTH data bytes in address order, XOR checksum of the data bytes.
module pixel_frame_reader
  import frame_pkg::*;
#(
  parameter int         DEPTH  = FRAME_BYTES,
  parameter int         ADDR_W = addr_width(DEPTH),
  parameter logic [7:0] HDR0   = FRAME_HDR0,
  parameter logic [7:0] HDR1   = FRAME_HDR1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  pixel_frame_reader_if.master bus,
  output logic          busy,
  output logic          done,
  output reader_state_t state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  reader_state_t     state_q;
  reader_state_t     state_d;
  logic [ADDR_W-1:0] raddr_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        csum_q;
  logic              tx_valid;
  logic              xfer;
  logic              last;

  // tx_valid is a pure state decode, so xfer never loops back into tx_valid.
  assign xfer = tx_valid & bus.tx_ready;
  assign last = (raddr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_HDR0;
      ST_HDR0:    if (xfer)  state_d = ST_HDR1;
      ST_HDR1:    if (xfer)  state_d = ST_RD_REQ;
      ST_RD_REQ:             state_d = ST_RD_WAIT;
      ST_RD_WAIT:            state_d = ST_SEND;
      ST_SEND:    if (xfer)  state_d = last ? ST_CSUM : ST_RD_REQ;
      ST_CSUM:    if (xfer)  state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    bus.rEn  = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    case (state_q)
      ST_HDR0, ST_HDR1, ST_SEND, ST_CSUM: tx_valid = 1'b1;
      ST_RD_REQ:                          bus.rEn  = 1'b1;
      default: ;
    endcase
  end

  // Address counter, outgoing byte and running checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q   <= '0;
      tx_data_q <= '0;
      csum_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            raddr_q   <= '0;
            csum_q    <= '0;
            tx_data_q <= HDR0;
          end
        end
        ST_HDR0: if (xfer) tx_data_q <= HDR1;
        ST_RD_WAIT: begin
          tx_data_q <= bus.rData;
          csum_q    <= csum_q ^ bus.rData;
        end
        ST_SEND: begin
          if (xfer) begin
            if (last) tx_data_q <= csum_q;
            else      raddr_q   <= raddr_q + 1'b1;
          end
        end
        ST_DONE: raddr_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.rAddr    = raddr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid;
  assign state        = state_q;

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Bench for pixel_frame_reader: a DEPTH=4 instance for the short packet and
// control corner cases, a full-size instance for the long randomly stalled packet.
module tb_pixel_frame_reader;
  import frame_pkg::*;

  localparam int SDEPTH = 4;
  localparam int BDEPTH = FRAME_BYTES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_s = 1'b1, start_s = 1'b0;
  logic reset_b = 1'b1, start_b = 1'b0;
  logic busy_s, done_o_s, busy_b, done_o_b;
  reader_state_t state_s, state_b;

  pixel_frame_reader_if #(.ADDR_W(addr_width(SDEPTH))) bs ();
  pixel_frame_reader_if #(.ADDR_W(addr_width(BDEPTH))) bb ();

  pixel_frame_reader #(.DEPTH(SDEPTH)) dut_s (
    .clk(clk), .reset(reset_s), .start(start_s), .bus(bs),
    .busy(busy_s), .done(done_o_s), .state(state_s)
  );

  pixel_frame_reader #(.DEPTH(BDEPTH)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .bus(bb),
    .busy(busy_b), .done(done_o_b), .state(state_b)
  );

  // ---------------- 1-cycle-latency sync RAM models ----------------
  logic [7:0] mem_s [SDEPTH];
  logic [7:0] mem_b [BDEPTH];
  initial begin
    bs.rData = 8'h00;
    bb.rData = 8'h00;
    for (int a = 0; a < BDEPTH; a++) mem_b[a] = a[7:0];
    for (int a = 0; a < SDEPTH; a++) mem_s[a] = 8'h00;
  end
  always @(posedge clk) if (bs.rEn) bs.rData <= mem_s[bs.rAddr];
  always @(posedge clk) if (bb.rEn) bb.rData <= mem_b[bb.rAddr];

  // ---------------- tx_ready drivers ----------------
  logic rmode_b = 1'b0;
  initial begin
    bs.tx_ready = 1'b1;
    bb.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      bb.tx_ready = rmode_b ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_s[$];
  logic [7:0] exp_b[$];
  int bytes_s = 0, ren_s = 0, done_cnt_s = 0;
  int bytes_b = 0, ren_b = 0, done_cnt_b = 0;
  logic stall_s = 1'b0, stall_b = 1'b0;
  logic [7:0] held_s, held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic extra_byte(input string name, input logic [7:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got byte %h, expected no transfer (t=%0t)", name, act, $time);
  endtask

  // Monitors sample 1 time unit after the inactive edge; a byte seen with
  // valid & ready here is transferred on the following posedge.
  always begin
    @(negedge clk); #1;
    if (reset_s) stall_s = 1'b0;
    else begin
      if (stall_s) begin
        check("stall_valid_s", 32'(bs.tx_valid), 32'd1);
        check("stall_data_s", 32'(bs.tx_data), 32'(held_s));
      end
      if (bs.tx_valid && bs.tx_ready) begin
        bytes_s++;
        if (exp_s.size() == 0) extra_byte("extra_byte_s", bs.tx_data);
        else check("byte_s", 32'(bs.tx_data), 32'(exp_s.pop_front()));
      end
      stall_s = bs.tx_valid && !bs.tx_ready;
      held_s  = bs.tx_data;
      if (bs.rEn) ren_s++;
      if (done_o_s) done_cnt_s++;
    end
  end

  always begin
    @(negedge clk); #1;
    if (reset_b) stall_b = 1'b0;
    else begin
      if (stall_b) begin
        check("stall_valid_b", 32'(bb.tx_valid), 32'd1);
        check("stall_data_b", 32'(bb.tx_data), 32'(held_b));
      end
      if (bb.tx_valid && bb.tx_ready) begin
        bytes_b++;
        if (exp_b.size() == 0) extra_byte("extra_byte_b", bb.tx_data);
        else check("byte_b", 32'(bb.tx_data), 32'(exp_b.pop_front()));
      end
      stall_b = bb.tx_valid && !bb.tx_ready;
      held_b  = bb.tx_data;
      if (bb.rEn) begin
        ren_b++;
        if (bb.rAddr > 13'(BDEPTH - 1)) check("raddr_range_b", 32'(bb.rAddr), 32'(BDEPTH - 1));
      end
      if (done_o_b) done_cnt_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start_s();
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  task automatic push_packet_b();
    logic [7:0] x;
    x = 8'h00;
    exp_b.push_back(8'hAA);
    exp_b.push_back(8'h55);
    for (int a = 0; a < BDEPTH; a++) begin
      exp_b.push_back(a[7:0]);
      x = x ^ a[7:0];
    end
    exp_b.push_back(x);
  endtask

  task automatic wait_done(input bit big, input int budget, input string name);
    int base = big ? done_cnt_b : done_cnt_s;
    int n = 0;
    while ((big ? done_cnt_b : done_cnt_s) == base && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if ((big ? done_cnt_b : done_cnt_s) == base) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_bytes_b(input int target, input int budget, input string name);
    int n = 0;
    while (bytes_b < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (bytes_b < target) check(name, 32'(bytes_b), 32'(target));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] ram;   // byte a at [8a +: 8]
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b0, r0, d0;

    vecs[0] = '{ram: 32'h08040201, csum: 8'h0F};
    vecs[1] = '{ram: 32'hFFFFFFFF, csum: 8'h00};
    vecs[2] = '{ram: 32'h00000000, csum: 8'h00};
    vecs[3] = '{ram: 32'hC33C5AA5, csum: 8'h00};
    vecs[4] = '{ram: 32'h11204080, csum: 8'hF1};
    vecs[5] = '{ram: 32'h55AA55AA, csum: 8'h00};

    // Reset held 3 cycles: every output at its reset value.
    repeat (3) @(negedge clk);
    check("rst_ren_s",    32'(bs.rEn),      32'd0);
    check("rst_raddr_s",  32'(bs.rAddr),    32'd0);
    check("rst_txdata_s", 32'(bs.tx_data),  32'd0);
    check("rst_valid_s",  32'(bs.tx_valid), 32'd0);
    check("rst_busy_s",   32'(busy_s),      32'd0);
    check("rst_done_s",   32'(done_o_s),    32'd0);
    check("rst_state_s",  32'(state_s),     32'(ST_IDLE));
    check("rst_valid_b",  32'(bb.tx_valid), 32'd0);
    check("rst_state_b",  32'(state_b),     32'(ST_IDLE));
    reset_s = 1'b0;
    reset_b = 1'b0;
    idle(4);
    check("idle_valid_s", 32'(bs.tx_valid), 32'd0);
    check("idle_bytes_s", 32'(bytes_s),     32'd0);

    // Table-driven short packets with tx_ready held high.
    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < SDEPTH; a++) mem_s[a] = vecs[v].ram[8*a +: 8];
      b0 = bytes_s; r0 = ren_s; d0 = done_cnt_s;
      exp_s.push_back(8'hAA);
      exp_s.push_back(8'h55);
      for (int a = 0; a < SDEPTH; a++) exp_s.push_back(vecs[v].ram[8*a +: 8]);
      exp_s.push_back(vecs[v].csum);
      pulse_start_s();
      wait_done(1'b0, 200, "timeout_done_s");
      idle(3);
      check("pkt_bytes_s", 32'(bytes_s - b0),    32'd7);
      check("pkt_ren_s",   32'(ren_s - r0),      32'd4);
      check("pkt_done_s",  32'(done_cnt_s - d0), 32'd1);
      check("pkt_left_s",  32'(exp_s.size()),    32'd0);
      check("pkt_busy_s",  32'(busy_s),          32'd0);
    end

    // start pulsed mid-packet and again during DONE: still one packet.
    for (int a = 0; a < SDEPTH; a++) mem_s[a] = vecs[0].ram[8*a +: 8];
    b0 = bytes_s; d0 = done_cnt_s;
    exp_s.push_back(8'hAA);
    exp_s.push_back(8'h55);
    for (int a = 0; a < SDEPTH; a++) exp_s.push_back(vecs[0].ram[8*a +: 8]);
    exp_s.push_back(vecs[0].csum);
    pulse_start_s();
    idle(4);
    pulse_start_s();
    begin
      int n = 0;
      while (state_s != ST_DONE && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reach_done_s", 32'(state_s), 32'(ST_DONE));
    end
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    idle(20);
    check("ign_bytes_s", 32'(bytes_s - b0),    32'd7);
    check("ign_done_s",  32'(done_cnt_s - d0), 32'd1);
    check("ign_busy_s",  32'(busy_s),          32'd0);

    // start and reset in the same cycle: reset wins.
    b0 = bytes_s;
    @(negedge clk); start_s = 1'b1; reset_s = 1'b1;
    @(negedge clk); start_s = 1'b0; reset_s = 1'b0;
    check("sr_state_s", 32'(state_s), 32'(ST_IDLE));
    check("sr_busy_s",  32'(busy_s),  32'd0);
    idle(5);
    check("sr_busy2_s", 32'(busy_s),       32'd0);
    check("sr_bytes_s", 32'(bytes_s - b0), 32'd0);

    // Full-size frame with random back-pressure.
    rmode_b = 1'b1;
    b0 = bytes_b; r0 = ren_b; d0 = done_cnt_b;
    push_packet_b();
    pulse_start_b();
    wait_done(1'b1, 60000, "timeout_done_b");
    idle(3);
    check("big_bytes_b", 32'(bytes_b - b0),    32'(BDEPTH + 3));
    check("big_ren_b",   32'(ren_b - r0),      32'(BDEPTH));
    check("big_done_b",  32'(done_cnt_b - d0), 32'd1);
    check("big_left_b",  32'(exp_b.size()),    32'd0);
    check("big_busy_b",  32'(busy_b),          32'd0);

    // Reset after the 10th data byte, then a fresh packet restarts from the header.
    rmode_b = 1'b0;
    idle(1);
    b0 = bytes_b; d0 = done_cnt_b;
    push_packet_b();
    pulse_start_b();
    wait_bytes_b(b0 + 12, 200, "timeout_ten_b");
    @(negedge clk); reset_b = 1'b1;
    exp_b.delete();
    @(negedge clk); reset_b = 1'b0;
    check("mrst_state_b", 32'(state_b),     32'(ST_IDLE));
    check("mrst_valid_b", 32'(bb.tx_valid), 32'd0);
    check("mrst_raddr_b", 32'(bb.rAddr),    32'd0);
    idle(3);
    check("mrst_done_b",  32'(done_cnt_b - d0), 32'd0);
    b0 = bytes_b;
    push_packet_b();
    pulse_start_b();
    wait_bytes_b(b0 + 5, 200, "timeout_restart_b");
    check("restart_bytes_b", 32'(bytes_b - b0), 32'd5);
    @(negedge clk); reset_b = 1'b1;
    exp_b.delete();
    @(negedge clk); reset_b = 1'b0;
    idle(3);
    check("restart_done_b", 32'(done_cnt_b - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
